// File: rtl/counter_pkg.sv
// counter_pkg: shared types, default parameters and helpers for the
// parametrised up/down counter family (param_updown_counter).
package counter_pkg;

    // Default parameter values for new instances.
    localparam int DEF_WIDTH       = 4;
    localparam int DEF_STALL_LIMIT = 4;

    // Width of the generic clamp helper; large enough for any counter width in use.
    localparam int CLAMP_W = 32;

    // Boundary behaviour decoded from the sat_mode pin.
    typedef enum logic [0:0] {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    // Limit a requested load value to the highest legal count.
    function automatic logic [CLAMP_W-1:0] clamp_load(
        input logic [CLAMP_W-1:0] val,
        input logic [CLAMP_W-1:0] max_val
    );
        logic [CLAMP_W-1:0] res;
        if (val > max_val) begin
            res = max_val;
        end else begin
            res = val;
        end
        return res;
    endfunction

endpackage

// File: rtl/counter_checker.sv
// counter_checker: observation-only property set for param_updown_counter.
// Compiled only when COUNTER_SVA_EN is defined; all checks are disabled
// while rst is asserted.
`ifdef COUNTER_SVA_EN
module counter_checker
    import counter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MAX_VAL = (2 ** WIDTH) - 1
) (
    input logic             clk,
    input logic             rst,
    input logic             enable,
    input logic             load,
    input logic [WIDTH-1:0] load_val,
    input logic             up,
    input logic             sat_mode,
    input logic             clr_err,
    input logic [WIDTH-1:0] count_val,
    input logic             tc,
    input logic             wrap,
    input logic             stall,
    input logic             load_err
);

    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};

    logic [WIDTH-1:0] w_clamped;
    logic             w_step;
    logic             w_at_top;
    logic             w_at_bot;
    logic             w_wrap_cond;

    assign w_clamped   = WIDTH'(clamp_load(CLAMP_W'(load_val), CLAMP_W'(MAX_VAL)));
    assign w_step      = enable && !load;
    assign w_at_top    = (count_val == MAX_C);
    assign w_at_bot    = (count_val == ZERO_C);
    assign w_wrap_cond = w_step && !sat_mode && ((up && w_at_top) || (!up && w_at_bot));

    a_load_value: assert property (@(posedge clk) disable iff (rst)
        load |=> count_val == $past(w_clamped));

    a_load_prio_err: assert property (@(posedge clk) disable iff (rst)
        (load && enable) |=> load_err);

    a_step_up: assert property (@(posedge clk) disable iff (rst)
        (w_step && up && !w_at_top) |=> count_val == $past(count_val) + WIDTH'(1));

    a_step_down: assert property (@(posedge clk) disable iff (rst)
        (w_step && !up && !w_at_bot) |=> count_val == $past(count_val) - WIDTH'(1));

    a_top_wrap: assert property (@(posedge clk) disable iff (rst)
        (w_step && up && w_at_top && !sat_mode) |=> (count_val == ZERO_C) && wrap);

    a_top_sat: assert property (@(posedge clk) disable iff (rst)
        (w_step && up && w_at_top && sat_mode) |=> count_val == MAX_C);

    a_bot_wrap: assert property (@(posedge clk) disable iff (rst)
        (w_step && !up && w_at_bot && !sat_mode) |=> (count_val == MAX_C) && wrap);

    a_bot_sat: assert property (@(posedge clk) disable iff (rst)
        (w_step && !up && w_at_bot && sat_mode) |=> count_val == ZERO_C);

    a_range: assert property (@(posedge clk) disable iff (rst)
        count_val <= MAX_C);

    a_wrap_pulse: assert property (@(posedge clk) disable iff (rst)
        1'b1 |=> wrap == $past(w_wrap_cond));

    a_tc_decode: assert property (@(posedge clk) disable iff (rst)
        tc == (up ? w_at_top : w_at_bot));

    a_stall_at_bound: assert property (@(posedge clk) disable iff (rst)
        stall |-> (w_at_top || w_at_bot));

    a_err_clear: assert property (@(posedge clk) disable iff (rst)
        (clr_err && !load) |=> !load_err);

endmodule
`endif

// File: rtl/param_updown_counter_stall.sv
// param_updown_counter_stall: counts consecutive cycles in which an
// enabled count was held at a saturation bound and flags a stall once the
// run reaches STALL_LIMIT. The run counter saturates so it never rolls over.
module param_updown_counter_stall #(
    parameter int STALL_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_hold,
    output logic o_stall
);

    localparam int SW = $clog2(STALL_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT_C = SW'(STALL_LIMIT);

    logic [SW-1:0] r_run;
    logic [SW-1:0] w_run_next;
    logic          r_stall;

    // Next run length: grow (saturating at the limit) while held, else restart.
    always_comb begin
        w_run_next = r_run;
        if (i_hold) begin
            if (r_run < LIMIT_C) begin
                w_run_next = r_run + SW'(1);
            end else begin
                w_run_next = r_run;
            end
        end else begin
            w_run_next = {SW{1'b0}};
        end
    end

    // Run-length register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run <= {SW{1'b0}};
        end else begin
            r_run <= w_run_next;
        end
    end

    // Stall flag follows the run length on the same edge it reaches the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall <= 1'b0;
        end else begin
            r_stall <= (w_run_next >= LIMIT_C);
        end
    end

    assign o_stall = r_stall;

endmodule

// File: rtl/param_updown_counter.sv
// param_updown_counter: loadable up/down counter with configurable width
// and modulus, wrap/saturate boundary handling, terminal-count and wrap
// indicators, a held-at-bound stall detector and a sticky protocol-error
// flag. Optional build macro: COUNTER_SVA_EN instantiates counter_checker.
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int MAX_VAL     = (2 ** WIDTH) - 1,
    parameter int STALL_LIMIT = DEF_STALL_LIMIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up,
    input  logic             sat_mode,
    input  logic             clr_err,
    output logic [WIDTH-1:0] count_val,
    output logic             tc,
    output logic             wrap,
    output logic             stall,
    output logic             load_err
);

    // Bounds are compared against MAX_VAL, not the natural 2**WIDTH rollover.
    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_load_err;

    logic [WIDTH-1:0] w_load_clamped;
    logic [WIDTH-1:0] w_count_next;
    logic             w_wrap_next;
    logic             w_hold;
    logic             w_err_set;
    logic             w_at_top;
    logic             w_at_bot;
    logic             w_stall;
    mode_e            w_mode;

    assign w_load_clamped = WIDTH'(clamp_load(CLAMP_W'(load_val), CLAMP_W'(MAX_VAL)));
    assign w_at_top       = (r_count == MAX_C);
    assign w_at_bot       = (r_count == ZERO_C);

    // Decode the boundary mode pin into its enumerated meaning.
    always_comb begin
        if (sat_mode) begin
            w_mode = MODE_SAT;
        end else begin
            w_mode = MODE_WRAP;
        end
    end

    // Next count: load beats enable beats hold; bounds wrap or hold by mode.
    always_comb begin
        w_count_next = r_count;
        w_wrap_next  = 1'b0;
        w_hold       = 1'b0;
        if (load) begin
            w_count_next = w_load_clamped;
        end else if (enable) begin
            if (up) begin
                if (!w_at_top) begin
                    w_count_next = r_count + WIDTH'(1);
                end else begin
                    case (w_mode)
                        MODE_WRAP: begin
                            w_count_next = ZERO_C;
                            w_wrap_next  = 1'b1;
                        end
                        MODE_SAT: begin
                            w_count_next = r_count;
                            w_hold       = 1'b1;
                        end
                        default: begin
                            w_count_next = r_count;
                        end
                    endcase
                end
            end else begin
                if (!w_at_bot) begin
                    w_count_next = r_count - WIDTH'(1);
                end else begin
                    case (w_mode)
                        MODE_WRAP: begin
                            w_count_next = MAX_C;
                            w_wrap_next  = 1'b1;
                        end
                        MODE_SAT: begin
                            w_count_next = r_count;
                            w_hold       = 1'b1;
                        end
                        default: begin
                            w_count_next = r_count;
                        end
                    endcase
                end
            end
        end else begin
            w_count_next = r_count;
        end
    end

    // Protocol errors: simultaneous load+enable, or an out-of-range load value.
    always_comb begin
        if (load && (enable || (load_val > MAX_C))) begin
            w_err_set = 1'b1;
        end else begin
            w_err_set = 1'b0;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= ZERO_C;
        end else begin
            r_count <= w_count_next;
        end
    end

    // Wrap pulse: high for the cycle following each wrapping edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_next;
        end
    end

    // Sticky error flag; a new error in the same cycle overrides the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load_err <= 1'b0;
        end else if (w_err_set) begin
            r_load_err <= 1'b1;
        end else if (clr_err) begin
            r_load_err <= 1'b0;
        end else begin
            r_load_err <= r_load_err;
        end
    end

    param_updown_counter_stall #(
        .STALL_LIMIT (STALL_LIMIT)
    ) u_stall (
        .clk     (clk),
        .rst     (rst),
        .i_hold  (w_hold),
        .o_stall (w_stall)
    );

`ifdef COUNTER_SVA_EN
    counter_checker #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_checker (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .load      (load),
        .load_val  (load_val),
        .up        (up),
        .sat_mode  (sat_mode),
        .clr_err   (clr_err),
        .count_val (r_count),
        .tc        (tc),
        .wrap      (r_wrap),
        .stall     (w_stall),
        .load_err  (r_load_err)
    );
`endif

    // Terminal count is a plain decode of the registered count and direction.
    assign tc        = up ? w_at_top : w_at_bot;
    assign count_val = r_count;
    assign wrap      = r_wrap;
    assign stall     = w_stall;
    assign load_err  = r_load_err;

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter: three instances (MAX 15, MAX 9, and a
// 2-bit MAX 1) share one stimulus stream; a per-instance arithmetic model
// is compared every cycle, plus hand-computed literal expectations.
module tb_param_updown_counter;

    localparam int STALL = 4;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       load;
    logic [3:0] load_val;
    logic       up;
    logic       sat_mode;
    logic       clr_err;

    logic [3:0] cnt15;
    logic [3:0] cnt9;
    logic [1:0] cnt1;
    logic [2:0] o_tc;
    logic [2:0] o_wrap;
    logic [2:0] o_stall;
    logic [2:0] o_err;

    int n_tests = 0;
    int n_fail  = 0;

    int m_cnt  [3];
    bit m_wrap [3];
    int m_held [3];
    bit m_err  [3];

    param_updown_counter #(.WIDTH(4)) dut15 (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .load_val(load_val),
        .up(up), .sat_mode(sat_mode), .clr_err(clr_err), .count_val(cnt15),
        .tc(o_tc[0]), .wrap(o_wrap[0]), .stall(o_stall[0]), .load_err(o_err[0]));

    param_updown_counter #(.WIDTH(4), .MAX_VAL(9)) dut9 (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .load_val(load_val),
        .up(up), .sat_mode(sat_mode), .clr_err(clr_err), .count_val(cnt9),
        .tc(o_tc[1]), .wrap(o_wrap[1]), .stall(o_stall[1]), .load_err(o_err[1]));

    param_updown_counter #(.WIDTH(2), .MAX_VAL(1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .load_val(load_val[1:0]),
        .up(up), .sat_mode(sat_mode), .clr_err(clr_err), .count_val(cnt1),
        .tc(o_tc[2]), .wrap(o_wrap[2]), .stall(o_stall[2]), .load_err(o_err[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int maxv(input int i);
        case (i)
            0: return 15;
            1: return 9;
            default: return 1;
        endcase
    endfunction

    function automatic int maskv(input int i);
        if (i == 2) return 3;
        return 15;
    endfunction

    function automatic int dut_cnt(input int i);
        case (i)
            0: return int'(cnt15);
            1: return int'(cnt9);
            default: return int'(cnt1);
        endcase
    endfunction

    // An enabled step that would leave 0..mx.
    function automatic bit f_oob(input int cnt, input int mx, input bit ld, input bit en, input bit u);
        int t;
        t = u ? cnt + 1 : cnt - 1;
        return !ld && en && (t < 0 || t > mx);
    endfunction

    function automatic int f_next(input int cnt, input int mx, input bit ld, input int lv,
                                  input bit en, input bit u, input bit sat);
        int t;
        if (ld) return (lv > mx) ? mx : lv;
        if (!en) return cnt;
        t = u ? cnt + 1 : cnt - 1;
        if (t >= 0 && t <= mx) return t;
        if (sat) return cnt;
        return (t > mx) ? 0 : mx;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model, updated on the same edges as the design.
    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_cnt[i]  <= 0;
                m_wrap[i] <= 1'b0;
                m_held[i] <= 0;
                m_err[i]  <= 1'b0;
            end else begin
                m_cnt[i]  <= f_next(m_cnt[i], maxv(i), load, int'(load_val) & maskv(i),
                                    enable, up, sat_mode);
                m_wrap[i] <= f_oob(m_cnt[i], maxv(i), load, enable, up) && !sat_mode;
                m_held[i] <= (f_oob(m_cnt[i], maxv(i), load, enable, up) && sat_mode)
                             ? m_held[i] + 1 : 0;
                if (load && (enable || ((int'(load_val) & maskv(i)) > maxv(i))))
                    m_err[i] <= 1'b1;
                else if (clr_err)
                    m_err[i] <= 1'b0;
                else
                    m_err[i] <= m_err[i];
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            check($sformatf("model count[%0d]", i), dut_cnt(i), m_cnt[i]);
            check($sformatf("model tc[%0d]", i), int'(o_tc[i]),
                  up ? int'(m_cnt[i] == maxv(i)) : int'(m_cnt[i] == 0));
            check($sformatf("model wrap[%0d]", i), int'(o_wrap[i]), int'(m_wrap[i]));
            check($sformatf("model stall[%0d]", i), int'(o_stall[i]), int'(m_held[i] >= STALL));
            check($sformatf("model load_err[%0d]", i), int'(o_err[i]), int'(m_err[i]));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; load = 1'b0; load_val = 4'd0;
        up = 1'b1; sat_mode = 1'b0; clr_err = 1'b0;
        tick(2);
        rst = 1'b0;
        check("reset count15", int'(cnt15), 0);
        check("reset tc up=1", int'(o_tc[0]), 0);
        up = 1'b0; #1;
        check("reset tc up=0", int'(o_tc[0]), 1);
        up = 1'b1;

        // Plain load of 9.
        load = 1'b1; load_val = 4'd9; tick(1);
        check("load9 count15", int'(cnt15), 9);
        check("load9 count9", int'(cnt9), 9);
        check("load9 err15", int'(o_err[0]), 0);

        // Load priority over enable.
        load_val = 4'd7; tick(1);
        check("load7 count15", int'(cnt15), 7);
        enable = 1'b1; load_val = 4'd3; tick(1);
        check("prio count15", int'(cnt15), 3);
        check("prio err15", int'(o_err[0]), 1);
        load = 1'b0; enable = 1'b0; tick(1);
        check("err sticky", int'(o_err[0]), 1);
        clr_err = 1'b1; tick(1);
        check("err cleared", int'(o_err[0]), 0);
        clr_err = 1'b0;

        // Out-of-range load and wrap upward.
        load = 1'b1; load_val = 4'd15; tick(1);
        check("clamp count9", int'(cnt9), 9);
        check("clamp err9", int'(o_err[1]), 1);
        check("noclamp err15", int'(o_err[0]), 0);
        load = 1'b0; clr_err = 1'b1; enable = 1'b1; up = 1'b1; tick(1);
        clr_err = 1'b0; enable = 1'b0;
        check("wrap up count15", int'(cnt15), 0);
        check("wrap up flag15", int'(o_wrap[0]), 1);
        check("wrap up count9", int'(cnt9), 0);
        tick(1);
        check("wrap pulse ends", int'(o_wrap[0]), 0);

        // Wrap downward.
        enable = 1'b1; up = 1'b0; tick(1);
        enable = 1'b0;
        check("wrap dn count15", int'(cnt15), 15);
        check("wrap dn flag15", int'(o_wrap[0]), 1);
        check("wrap dn count9", int'(cnt9), 9);
        tick(1);

        // Saturate at the top and build a stall.
        sat_mode = 1'b1; up = 1'b1; load = 1'b1; load_val = 4'd15; tick(1);
        load = 1'b0; enable = 1'b1; tick(3);
        check("stall after 3", int'(o_stall[0]), 0);
        tick(1);
        check("stall after 4", int'(o_stall[0]), 1);
        check("stall9 after 4", int'(o_stall[1]), 1);
        tick(1);
        check("sat count15", int'(cnt15), 15);
        check("stall after 5", int'(o_stall[0]), 1);
        enable = 1'b0; tick(1);
        check("stall drop", int'(o_stall[0]), 0);

        // Mixed directed walk, model-checked every cycle.
        for (int k = 0; k < 60; k++) begin
            load     = (k % 13 == 5);
            load_val = 4'(k * 7);
            enable   = (k % 4 != 3);
            up       = ((k / 9) % 2 == 0);
            sat_mode = ((k / 17) % 2 == 1);
            clr_err  = (k % 10 == 9);
            tick(1);
        end

        // Asynchronous reset in the middle of a stall with an error pending.
        sat_mode = 1'b1; up = 1'b1; clr_err = 1'b0;
        load = 1'b1; enable = 1'b1; load_val = 4'd15; tick(1);
        load = 1'b0; tick(4);
        check("pre-rst stall", int'(o_stall[0]), 1);
        check("pre-rst err", int'(o_err[0]), 1);
        @(posedge clk); #3;
        rst = 1'b1; #1;
        check("async rst count", int'(cnt15), 0);
        check("async rst stall", int'(o_stall[0]), 0);
        check("async rst err", int'(o_err[0]), 0);
        check("async rst wrap", int'(o_wrap[0]), 0);
        tick(1);
        rst = 1'b0; enable = 1'b0;
        tick(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
